top_file_controller: RTL and testbench
======================================

TOP_FILE_CONTROLLER -- requirements
Module: top_file_controller

Interface
REQ-001 Parameter CONTROLLER_SIGNAL_WIDTH, default 14, SHALL set the control vector width; only 14 is supported.
REQ-002 Parameter NUM_CLAUSES, default 4, SHALL set the clause-loop count per iteration; range 1..1024.
REQ-003 Parameter MAX_ITER, default 2, SHALL set the number of select/evaluate iterations per run; range 1..65535.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port start, input, 1: run request, sampled on the rising edge of clk.
REQ-007 Port done, output, 1: run-complete pulse.
REQ-008 Port control_signal_o, output, 14: datapath control vector, decoded from state.

Function
REQ-009 The FSM SHALL have the states IDLE, LOAD, SELECT_UNSAT_CLAUSES, READ_CLAUSE_TABLE, READ_VARIABLE_TABLE, EVALUATE_CLAUSE, COUNT_UNSAT_CLAUSES, GATHER_UNSAT_CLAUSES, SELECT_UNSAT_CLAUSES_AGAIN and DONE.
REQ-010 control_signal_o SHALL be a pure function of state (Moore output), as follows:
- IDLE: 14'b00000000000000
- LOAD: 14'b01000000000000
- SELECT_UNSAT_CLAUSES: 14'b10000000000001
- READ_CLAUSE_TABLE: 14'b00100000000000
- READ_VARIABLE_TABLE: 14'b00001000000000
- EVALUATE_CLAUSE: 14'b00000001100000
- COUNT_UNSAT_CLAUSES: 14'b00000000000000
- GATHER_UNSAT_CLAUSES: 14'b00000000000100
- SELECT_UNSAT_CLAUSES_AGAIN: 14'b00000000000010
- DONE: 14'b00000000000000
REQ-011 IDLE SHALL go to LOAD when start=1; start is ignored in every other state, so pulses mid-run have no effect.
REQ-012 LOAD SHALL go to SELECT_UNSAT_CLAUSES and SHALL clear the clause counter and the iteration counter.
REQ-013 SELECT_UNSAT_CLAUSES SHALL go to READ_CLAUSE_TABLE and SHALL clear the clause counter.
REQ-014 READ_CLAUSE_TABLE SHALL go to READ_VARIABLE_TABLE, which SHALL go to EVALUATE_CLAUSE.
REQ-015 EVALUATE_CLAUSE SHALL act on the clause counter as follows:
- if clause counter = NUM_CLAUSES-1: go to COUNT_UNSAT_CLAUSES;
- otherwise: increment the counter and go to READ_CLAUSE_TABLE.
REQ-016 COUNT_UNSAT_CLAUSES SHALL go to GATHER_UNSAT_CLAUSES, which SHALL go to SELECT_UNSAT_CLAUSES_AGAIN.
REQ-017 SELECT_UNSAT_CLAUSES_AGAIN SHALL act on the iteration counter as follows:
- if iteration counter = MAX_ITER-1: go to DONE;
- otherwise: increment the counter and go to SELECT_UNSAT_CLAUSES.
REQ-018 DONE SHALL go to IDLE unconditionally; done SHALL be 1 only while in DONE (exactly one cycle per run).
REQ-019 Run latency: if start is sampled at edge E0, done SHALL be high between edges E0+1+MAX_ITER*(3*NUM_CLAUSES+4) and the next edge. With defaults, that is E33 to E34.
REQ-020 Counter widths SHALL be $clog2 of their limit, minimum 1 bit; counters SHALL never wrap beyond their limit.
REQ-021 start=1 while in DONE SHALL NOT start a new run; start must be sampled in IDLE.
REQ-022 Any encoding of an unused state SHALL return to IDLE on the next edge.

Reset
REQ-023 rst=0 SHALL immediately, without waiting for a clock edge, force IDLE, clear both counters, and drive done=0 and control_signal_o=0.
REQ-024 Reset asserted mid-run SHALL abort the run; no done pulse SHALL follow, and a fresh start is required after release.

Structure
REQ-025 A shared package top_file_controller_pkg SHALL hold the state enum and the ten control-vector localparams.
REQ-026 The design SHALL be one module (next-state logic, state register, counters, output decode), with no sub-module.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset 5 cycles, then release with start=0: control_signal_o=0, done=0, state stays IDLE.
- One-cycle start pulse with defaults: sequence LOAD, SELECT (14'b10000000000001), then 4x {00100000000000, 00001000000000, 00000001100000}, then 0, 100, 10; repeated twice; done=1 for exactly one cycle at E33.
- Start pulse, then rst=0 after 5 cycles for 1 cycle: immediate IDLE, outputs 0, no done; a new start then gives a full 34-cycle run.
- Two start pulses 3 cycles apart: the second is ignored; exactly one done, at E33 from the first.
- start held high through DONE: IDLE is re-entered, then LOAD on the following edge.
- NUM_CLAUSES=1, MAX_ITER=1: done at E8.

Source files
------------

// File: rtl/top_file_controller_pkg.sv
// Shared definitions for the clause-evaluation sequencer: the state encoding,
// the per-state datapath control words, and small elaboration helpers.
package top_file_controller_pkg;

    localparam int CTRL_W = 14;

    typedef enum logic [3:0] {
        S_IDLE                       = 4'd0,
        S_LOAD                       = 4'd1,
        S_SELECT_UNSAT_CLAUSES       = 4'd2,
        S_READ_CLAUSE_TABLE          = 4'd3,
        S_READ_VARIABLE_TABLE        = 4'd4,
        S_EVALUATE_CLAUSE            = 4'd5,
        S_COUNT_UNSAT_CLAUSES        = 4'd6,
        S_GATHER_UNSAT_CLAUSES       = 4'd7,
        S_SELECT_UNSAT_CLAUSES_AGAIN = 4'd8,
        S_DONE                       = 4'd9
    } state_t;

    localparam logic [CTRL_W-1:0] CTRL_IDLE                       = 14'b00000000000000;
    localparam logic [CTRL_W-1:0] CTRL_LOAD                       = 14'b01000000000000;
    localparam logic [CTRL_W-1:0] CTRL_SELECT_UNSAT_CLAUSES       = 14'b10000000000001;
    localparam logic [CTRL_W-1:0] CTRL_READ_CLAUSE_TABLE          = 14'b00100000000000;
    localparam logic [CTRL_W-1:0] CTRL_READ_VARIABLE_TABLE        = 14'b00001000000000;
    localparam logic [CTRL_W-1:0] CTRL_EVALUATE_CLAUSE            = 14'b00000001100000;
    localparam logic [CTRL_W-1:0] CTRL_COUNT_UNSAT_CLAUSES        = 14'b00000000000000;
    localparam logic [CTRL_W-1:0] CTRL_GATHER_UNSAT_CLAUSES       = 14'b00000000000100;
    localparam logic [CTRL_W-1:0] CTRL_SELECT_UNSAT_CLAUSES_AGAIN = 14'b00000000000010;
    localparam logic [CTRL_W-1:0] CTRL_DONE                       = 14'b00000000000000;

    // Control word driven while the FSM sits in a given state.
    function automatic logic [CTRL_W-1:0] ctrl_decode(input state_t s);
        logic [CTRL_W-1:0] c;
        case (s)
            S_IDLE:                       c = CTRL_IDLE;
            S_LOAD:                       c = CTRL_LOAD;
            S_SELECT_UNSAT_CLAUSES:       c = CTRL_SELECT_UNSAT_CLAUSES;
            S_READ_CLAUSE_TABLE:          c = CTRL_READ_CLAUSE_TABLE;
            S_READ_VARIABLE_TABLE:        c = CTRL_READ_VARIABLE_TABLE;
            S_EVALUATE_CLAUSE:            c = CTRL_EVALUATE_CLAUSE;
            S_COUNT_UNSAT_CLAUSES:        c = CTRL_COUNT_UNSAT_CLAUSES;
            S_GATHER_UNSAT_CLAUSES:       c = CTRL_GATHER_UNSAT_CLAUSES;
            S_SELECT_UNSAT_CLAUSES_AGAIN: c = CTRL_SELECT_UNSAT_CLAUSES_AGAIN;
            S_DONE:                       c = CTRL_DONE;
            default:                      c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    // Counter width for a loop limit; a limit of 1 still needs one bit.
    function automatic int cnt_width(input int limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/top_file_controller.sv
// Clause-evaluation sequencer. Runs MAX_ITER select/evaluate iterations, each
// walking NUM_CLAUSES clauses through read-clause / read-variable / evaluate,
// and pulses done for one cycle at the end of the run.
//
// state                        | meaning
// -----------------------------+---------------------------------------------
// S_IDLE                       | waiting for start
// S_LOAD                       | load problem, clear clause and iteration counts
// S_SELECT_UNSAT_CLAUSES       | pick working clause set, clear clause count
// S_READ_CLAUSE_TABLE          | fetch current clause
// S_READ_VARIABLE_TABLE        | fetch variables of current clause
// S_EVALUATE_CLAUSE            | evaluate clause, advance or leave clause loop
// S_COUNT_UNSAT_CLAUSES        | tally unsatisfied clauses
// S_GATHER_UNSAT_CLAUSES       | collect unsatisfied clauses
// S_SELECT_UNSAT_CLAUSES_AGAIN | advance iteration or finish
// S_DONE                       | one-cycle completion, back to idle
module top_file_controller
    import top_file_controller_pkg::*;
#(
    parameter int CONTROLLER_SIGNAL_WIDTH = 14,
    parameter int NUM_CLAUSES             = 4,
    parameter int MAX_ITER                = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    output logic                               done,
    output logic [CONTROLLER_SIGNAL_WIDTH-1:0] control_signal_o
);

    localparam int CLAUSE_W = cnt_width(NUM_CLAUSES);
    localparam int ITER_W   = cnt_width(MAX_ITER);

    localparam logic [CLAUSE_W-1:0] CLAUSE_LAST = CLAUSE_W'(NUM_CLAUSES - 1);
    localparam logic [ITER_W-1:0]   ITER_LAST   = ITER_W'(MAX_ITER - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CLAUSE_W-1:0] clause_cnt;
    logic [ITER_W-1:0]   iter_cnt;
    logic                clause_clr;
    logic                clause_inc;
    logic                iter_clr;
    logic                iter_inc;

    // Next-state and counter-action selection from current state and counters.
    always_comb begin
        state_nxt  = state;
        clause_clr = 1'b0;
        clause_inc = 1'b0;
        iter_clr   = 1'b0;
        iter_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                clause_clr = 1'b1;
                iter_clr   = 1'b1;
                state_nxt  = S_SELECT_UNSAT_CLAUSES;
            end
            S_SELECT_UNSAT_CLAUSES: begin
                clause_clr = 1'b1;
                state_nxt  = S_READ_CLAUSE_TABLE;
            end
            S_READ_CLAUSE_TABLE: begin
                state_nxt = S_READ_VARIABLE_TABLE;
            end
            S_READ_VARIABLE_TABLE: begin
                state_nxt = S_EVALUATE_CLAUSE;
            end
            S_EVALUATE_CLAUSE: begin
                if (clause_cnt == CLAUSE_LAST) begin
                    state_nxt = S_COUNT_UNSAT_CLAUSES;
                end else begin
                    clause_inc = 1'b1;
                    state_nxt  = S_READ_CLAUSE_TABLE;
                end
            end
            S_COUNT_UNSAT_CLAUSES: begin
                state_nxt = S_GATHER_UNSAT_CLAUSES;
            end
            S_GATHER_UNSAT_CLAUSES: begin
                state_nxt = S_SELECT_UNSAT_CLAUSES_AGAIN;
            end
            S_SELECT_UNSAT_CLAUSES_AGAIN: begin
                if (iter_cnt == ITER_LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    iter_inc  = 1'b1;
                    state_nxt = S_SELECT_UNSAT_CLAUSES;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and outputs; outputs are decoded from the next state so
    // the registered values always line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= S_IDLE;
            clause_cnt       <= '0;
            iter_cnt         <= '0;
            done             <= 1'b0;
            control_signal_o <= '0;
        end else begin
            state <= state_nxt;
            if (clause_clr) begin
                clause_cnt <= '0;
            end else if (clause_inc) begin
                clause_cnt <= clause_cnt + 1'b1;
            end
            if (iter_clr) begin
                iter_cnt <= '0;
            end else if (iter_inc) begin
                iter_cnt <= iter_cnt + 1'b1;
            end
            done             <= (state_nxt == S_DONE);
            control_signal_o <= CONTROLLER_SIGNAL_WIDTH'(ctrl_decode(state_nxt));
        end
    end

endmodule

// File: tb/tb_top_file_controller.sv
// Scoreboard bench for the clause-evaluation sequencer. Two instances: the
// default configuration and a single-clause single-iteration one.
module tb_top_file_controller;

    localparam logic [13:0] C_IDLE  = 14'b00000000000000;
    localparam logic [13:0] C_LOAD  = 14'b01000000000000;
    localparam logic [13:0] C_SEL   = 14'b10000000000001;
    localparam logic [13:0] C_RCT   = 14'b00100000000000;
    localparam logic [13:0] C_RVT   = 14'b00001000000000;
    localparam logic [13:0] C_EVAL  = 14'b00000001100000;
    localparam logic [13:0] C_COUNT = 14'b00000000000000;
    localparam logic [13:0] C_GATH  = 14'b00000000000100;
    localparam logic [13:0] C_AGAIN = 14'b00000000000010;
    localparam logic [13:0] C_DONE  = 14'b00000000000000;

    typedef struct {
        logic [13:0] c1;
        logic        d1;
        logic [13:0] c2;
        logic        d2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1;
    logic        start2;
    logic        done1;
    logic        done2;
    logic [13:0] ctrl1;
    logic [13:0] ctrl2;

    exp_t        sb_q[$];
    logic [13:0] seq4[$];
    logic [13:0] seq1[$];
    logic [13:0] tmp[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;

    always #5 clk = ~clk;

    top_file_controller #(
        .CONTROLLER_SIGNAL_WIDTH(14),
        .NUM_CLAUSES(4),
        .MAX_ITER(2)
    ) dut_def (
        .clk(clk),
        .rst(rst),
        .start(start1),
        .done(done1),
        .control_signal_o(ctrl1)
    );

    top_file_controller #(
        .CONTROLLER_SIGNAL_WIDTH(14),
        .NUM_CLAUSES(1),
        .MAX_ITER(1)
    ) dut_min (
        .clk(clk),
        .rst(rst),
        .start(start2),
        .done(done2),
        .control_signal_o(ctrl2)
    );

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d: got %b, expected %b", name, cyc, act, exp);
    endtask

    // Expected control word sequence of one run, starting at the LOAD cycle.
    task automatic build(input int nc, input int mi);
        tmp.delete();
        tmp.push_back(C_LOAD);
        for (int it = 0; it < mi; it++) begin
            tmp.push_back(C_SEL);
            for (int c = 0; c < nc; c++) begin
                tmp.push_back(C_RCT);
                tmp.push_back(C_RVT);
                tmp.push_back(C_EVAL);
            end
            tmp.push_back(C_COUNT);
            tmp.push_back(C_GATH);
            tmp.push_back(C_AGAIN);
        end
        tmp.push_back(C_DONE);
    endtask

    function automatic logic [13:0] lk_ctrl(input logic [13:0] q[$], input int k);
        if (k < 0 || k >= q.size()) return C_IDLE;
        return q[k];
    endfunction

    function automatic logic lk_done(input logic [13:0] q[$], input int k);
        return (k == q.size() - 1);
    endfunction

    // One clock of stimulus; k1/k2 index the expected run sequence of each
    // instance for the state reached at the coming edge (out of range = idle).
    task automatic step(input logic s1, input logic s2, input logic r, input int k1, input int k2);
        exp_t e;
        @(negedge clk);
        #1;
        start1 = s1;
        start2 = s2;
        rst    = r;
        if (!r) begin
            #1;
            check("rst_async_ctrl_def", ctrl1, C_IDLE);
            check("rst_async_done_def", {13'b0, done1}, 14'd0);
            check("rst_async_ctrl_min", ctrl2, C_IDLE);
            check("rst_async_done_min", {13'b0, done2}, 14'd0);
        end
        e.c1 = r ? lk_ctrl(seq4, k1) : C_IDLE;
        e.d1 = r ? lk_done(seq4, k1) : 1'b0;
        e.c2 = r ? lk_ctrl(seq1, k2) : C_IDLE;
        e.d2 = r ? lk_done(seq1, k2) : 1'b0;
        sb_q.push_back(e);
    endtask

    // Monitor: every cycle that has a queued expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("ctrl_def", ctrl1, e.c1);
                check("done_def", {13'b0, done1}, {13'b0, e.d1});
                check("ctrl_min", ctrl2, e.c2);
                check("done_min", {13'b0, done2}, {13'b0, e.d2});
            end
        end
    end

    initial begin
        rst    = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        build(4, 2);
        seq4 = tmp;
        build(1, 1);
        seq1 = tmp;

        // Reset for 5 cycles, release with start low: stays idle.
        for (int i = 0; i < 5; i++) step(0, 0, 0, -1, -1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, -1, -1);

        // Single start pulse, full default run, done at E33 only.
        step(1, 0, 1, 0, -1);
        for (int k = 1; k <= 37; k++) step(0, 0, 1, k, -1);

        // Reset five cycles into a run: abort, no done, then a fresh run.
        step(1, 0, 1, 0, -1);
        for (int k = 1; k <= 4; k++) step(0, 0, 1, k, -1);
        step(0, 0, 0, -1, -1);
        for (int i = 0; i < 36; i++) step(0, 0, 1, -1, -1);
        step(1, 0, 1, 0, -1);
        for (int k = 1; k <= 36; k++) step(0, 0, 1, k, -1);

        // Second pulse three cycles later is ignored.
        step(1, 0, 1, 0, -1);
        for (int k = 1; k <= 36; k++) step((k == 3) ? 1'b1 : 1'b0, 0, 1, k, -1);

        // start held through DONE: idle first, then LOAD on the next edge.
        for (int k = 0; k <= 34; k++) step(1, 0, 1, k, -1);
        step(1, 0, 1, 0, -1);
        for (int k = 1; k <= 36; k++) step(0, 0, 1, k, -1);

        // Minimal configuration: done at E8.
        step(0, 1, 1, -1, 0);
        for (int k = 1; k <= 11; k++) step(0, 0, 1, -1, k);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 14'(sb_q.size()), 14'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
